// File: rtl/mini_core_wb_pkg.sv
// Shared types for the mini_core write-back stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mini_core_wb_pkg;

  // Write-back source select; encoding 3 is decoded as WB_ALU.
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_PC4  = 2'd1,
    WB_LOAD = 2'd2
  } t_wb_sel;

  // Load access size; encoding 3 is decoded as LD_W.
  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2
  } t_ld_size;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_RSP = 1'b1
  } t_wb_state;

endpackage

// File: rtl/mini_core_wb_if.sv
// Bundle of Q103H inputs, memory response and Q104H register-file write port.
// Latency: n/a (wires only).
// Backpressure: ReadyQ103H flows back to the Q103H producer.
// Ports: master = upstream/memory/rf side, slave = write-back stage.
interface mini_core_wb_if;
  logic        ValidQ103H;
  logic        RegWrEnQ103H;
  logic [4:0]  RegDstQ103H;
  logic [1:0]  WbSelQ103H;
  logic [1:0]  LdSizeQ103H;
  logic        LdSignExtQ103H;
  logic [1:0]  AddrLsbQ103H;
  logic [31:0] AluOutQ103H;
  logic [31:0] PcPlus4Q103H;
  logic        MemRspValid;
  logic [31:0] MemRspData;
  logic        ReadyQ103H;
  logic        RegWrEnQ104H;
  logic [4:0]  RegDstQ104H;
  logic [31:0] RegWrDataQ104H;
  logic        LdTimeout;

  modport master (
    output ValidQ103H, RegWrEnQ103H, RegDstQ103H, WbSelQ103H, LdSizeQ103H,
           LdSignExtQ103H, AddrLsbQ103H, AluOutQ103H, PcPlus4Q103H,
           MemRspValid, MemRspData,
    input  ReadyQ103H, RegWrEnQ104H, RegDstQ104H, RegWrDataQ104H, LdTimeout
  );

  modport slave (
    input  ValidQ103H, RegWrEnQ103H, RegDstQ103H, WbSelQ103H, LdSizeQ103H,
           LdSignExtQ103H, AddrLsbQ103H, AluOutQ103H, PcPlus4Q103H,
           MemRspValid, MemRspData,
    output ReadyQ103H, RegWrEnQ104H, RegDstQ104H, RegWrDataQ104H, LdTimeout
  );
endinterface

// File: rtl/mini_core_ld_align.sv
// Load data alignment and sign/zero extension.
// Latency: combinational.
// Backpressure: none.
// Ports: rsp_data (raw word), addr_lsb, ld_size, sign_ext -> result.
module mini_core_ld_align
  import mini_core_wb_pkg::*;
(
  input  logic [31:0] rsp_data,
  input  logic [1:0]  addr_lsb,
  input  logic [1:0]  ld_size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Right shift zero-fills, so a halfword at byte 3 naturally gets a zero
  // upper byte before extension (no trap on misalignment).
  assign shifted = rsp_data >> {addr_lsb, 3'b000};

  always_comb begin
    result = rsp_data;
    case (ld_size)
      LD_B:    result = {{24{sign_ext & shifted[7]}},  shifted[7:0]};
      LD_H:    result = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: result = rsp_data;
    endcase
  end

endmodule

// File: rtl/mini_core_wb.sv
// Write-back stage: selects ALU / PC+4 / aligned load data, drives the RF write port.
// Latency: 1 cycle from accept (or from memory response) to Q104H outputs.
// Backpressure: ReadyQ103H=0 while a load waits for its response; LD_TIMEOUT aborts the wait.
// Ports: Clock, Rst (async active-low), wb (slave side of mini_core_wb_if).
module mini_core_wb
  import mini_core_wb_pkg::*;
#(
  parameter int LD_TIMEOUT = 255
) (
  input  logic          Clock,
  input  logic          Rst,
  mini_core_wb_if.slave wb
);

  localparam int CNT_W = $clog2(LD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LD_TIMEOUT - 1);

  t_wb_state        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_wr_en_q, ld_wr_en_d;
  logic [4:0]       ld_dst_q, ld_dst_d;
  logic [1:0]       ld_size_q, ld_size_d;
  logic             ld_sext_q, ld_sext_d;
  logic [1:0]       ld_lsb_q, ld_lsb_d;
  logic             wr_en_q, wr_en_d;
  logic [4:0]       wr_dst_q, wr_dst_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             timeout_q, timeout_d;

  logic             ready;
  logic             accept;
  logic             is_load;
  logic             wr_gate;
  logic [1:0]       al_size;
  logic             al_sext;
  logic [1:0]       al_lsb;
  logic [31:0]      al_result;

  // Writes to x0 are suppressed at the source so the RF never sees them.
  assign accept  = wb.ValidQ103H && ready;
  assign is_load = (wb.WbSelQ103H == WB_LOAD);
  assign wr_gate = wb.RegWrEnQ103H && (wb.RegDstQ103H != 5'd0);

  // While waiting, the aligner must use the ctrl captured at accept time,
  // because the Q103H inputs no longer belong to this load.
  always_comb begin
    al_size = wb.LdSizeQ103H;
    al_sext = wb.LdSignExtQ103H;
    al_lsb  = wb.AddrLsbQ103H;
    if (state_q == WB_WAIT_RSP) begin
      al_size = ld_size_q;
      al_sext = ld_sext_q;
      al_lsb  = ld_lsb_q;
    end
  end

  mini_core_ld_align u_ld_align (
    .rsp_data (wb.MemRspData),
    .addr_lsb (al_lsb),
    .ld_size  (al_size),
    .sign_ext (al_sext),
    .result   (al_result)
  );

  // State register and all other flops.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q    <= WB_IDLE;
      cnt_q      <= '0;
      ld_wr_en_q <= 1'b0;
      ld_dst_q   <= '0;
      ld_size_q  <= '0;
      ld_sext_q  <= 1'b0;
      ld_lsb_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_dst_q   <= '0;
      wr_data_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_wr_en_q <= ld_wr_en_d;
      ld_dst_q   <= ld_dst_d;
      ld_size_q  <= ld_size_d;
      ld_sext_q  <= ld_sext_d;
      ld_lsb_q   <= ld_lsb_d;
      wr_en_q    <= wr_en_d;
      wr_dst_q   <= wr_dst_d;
      wr_data_q  <= wr_data_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_wr_en_d = ld_wr_en_q;
    ld_dst_d   = ld_dst_q;
    ld_size_d  = ld_size_q;
    ld_sext_d  = ld_sext_q;
    ld_lsb_d   = ld_lsb_q;
    wr_en_d    = 1'b0;          // write enable is a one-cycle pulse
    wr_dst_d   = wr_dst_q;
    wr_data_d  = wr_data_q;
    timeout_d  = timeout_q;

    case (state_q)
      WB_IDLE: begin
        if (accept) begin
          if (!is_load) begin
            wr_en_d   = wr_gate;
            wr_dst_d  = wb.RegDstQ103H;
            wr_data_d = (wb.WbSelQ103H == WB_PC4) ? wb.PcPlus4Q103H : wb.AluOutQ103H;
          end else if (wb.MemRspValid) begin
            // Zero-wait load: response arrived with the instruction.
            wr_en_d   = wr_gate;
            wr_dst_d  = wb.RegDstQ103H;
            wr_data_d = al_result;
          end else begin
            state_d    = WB_WAIT_RSP;
            cnt_d      = '0;
            ld_wr_en_d = wr_gate;
            ld_dst_d   = wb.RegDstQ103H;
            ld_size_d  = wb.LdSizeQ103H;
            ld_sext_d  = wb.LdSignExtQ103H;
            ld_lsb_d   = wb.AddrLsbQ103H;
          end
        end
      end
      WB_WAIT_RSP: begin
        // A response in the final allowed cycle still wins over the abort.
        if (wb.MemRspValid) begin
          state_d   = WB_IDLE;
          wr_en_d   = ld_wr_en_q;
          wr_dst_d  = ld_dst_q;
          wr_data_d = al_result;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = WB_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    ready = (state_q == WB_IDLE);
  end

  assign wb.ReadyQ103H     = ready;
  assign wb.RegWrEnQ104H   = wr_en_q;
  assign wb.RegDstQ104H    = wr_dst_q;
  assign wb.RegWrDataQ104H = wr_data_q;
  assign wb.LdTimeout      = timeout_q;

endmodule
